// File: rtl/lockstep_periph_master.sv
// Single-outstanding peripheral bus master.
// Accepts one local command, issues it on the peripheral request channel,
// waits for the matching response and returns it as a one-cycle pulse.
// A saturating per-phase timeout turns a missing grant or a missing
// response into an error response.
module lockstep_periph_master #(
  parameter int ID_WIDTH   = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MASTER_ID  = 0,
  parameter int TIMEOUT    = 255
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  // local command side
  input  logic                    cmd_valid_i,
  output logic                    cmd_ready_o,
  input  logic                    cmd_wen_i,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr_i,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] cmd_be_i,
  output logic                    rsp_valid_o,
  output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
  output logic                    rsp_err_o,
  // peripheral request channel
  output logic                    req_o,
  output logic [ADDR_WIDTH-1:0]   add_o,
  output logic                    wen_o,
  output logic [DATA_WIDTH-1:0]   wdata_o,
  output logic [DATA_WIDTH/8-1:0] be_o,
  output logic [ID_WIDTH-1:0]     id_o,
  input  logic                    gnt_i,
  // peripheral response channel
  input  logic                    r_valid_i,
  input  logic                    r_opc_i,
  input  logic [ID_WIDTH-1:0]     r_id_i,
  input  logic [DATA_WIDTH-1:0]   r_rdata_i,
  output logic                    busy_o
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_REQ      = 2'd1;
  localparam logic [1:0] S_WAIT_RSP = 2'd2;
  localparam logic [1:0] S_RESP     = 2'd3;

  localparam logic [ID_WIDTH-1:0] MID      = ID_WIDTH'(MASTER_ID);
  localparam logic [15:0]         TO_LIMIT = 16'(TIMEOUT);

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [1:0]              state;
  logic [15:0]             cnt;
  logic [15:0]             cnt_inc;
  logic                    timed_out;

  // command stage registers (held until the next accepted command)
  logic                    wen_p0;
  logic [ADDR_WIDTH-1:0]   addr_p0;
  logic [DATA_WIDTH-1:0]   wdata_p0;
  logic [DATA_WIDTH/8-1:0] be_p0;
  logic [ID_WIDTH-1:0]     id_p0;

  // response stage registers
  logic [DATA_WIDTH-1:0]   rdata_p1;
  logic                    err_p1;

  assign cnt_inc   = sat_inc(cnt);
  assign timed_out = (cnt_inc >= TO_LIMIT);

  // FSM, phase timeout counter, command capture and response capture.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state    <= S_IDLE;
      cnt      <= 16'd0;
      wen_p0   <= 1'b0;
      addr_p0  <= '0;
      wdata_p0 <= '0;
      be_p0    <= '0;
      id_p0    <= '0;
      rdata_p1 <= '0;
      err_p1   <= 1'b0;
    end else begin
      case (state)
        // command accept -> request stage
        S_IDLE: begin
          if (cmd_valid_i) begin
            wen_p0   <= cmd_wen_i;
            addr_p0  <= cmd_addr_i;
            wdata_p0 <= cmd_wdata_i;
            be_p0    <= cmd_be_i;
            id_p0    <= MID;
            cnt      <= 16'd0;
            state    <= S_REQ;
          end
        end
        // request stage -> response wait (grant beats a same-cycle timeout)
        S_REQ: begin
          if (gnt_i) begin
            cnt   <= 16'd0;
            state <= S_WAIT_RSP;
          end else if (timed_out) begin
            rdata_p1 <= '0;
            err_p1   <= 1'b1;
            cnt      <= 16'd0;
            state    <= S_RESP;
          end else begin
            cnt <= cnt_inc;
          end
        end
        // response wait -> response stage
        S_WAIT_RSP: begin
          if (r_valid_i) begin
            rdata_p1 <= wen_p0 ? r_rdata_i : '0;
            err_p1   <= r_opc_i | (r_id_i != MID);
            cnt      <= 16'd0;
            state    <= S_RESP;
          end else if (timed_out) begin
            rdata_p1 <= '0;
            err_p1   <= 1'b1;
            cnt      <= 16'd0;
            state    <= S_RESP;
          end else begin
            cnt <= cnt_inc;
          end
        end
        S_RESP: begin
          cnt   <= 16'd0;
          state <= S_IDLE;
        end
        default: begin
          cnt   <= 16'd0;
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready_o = (state == S_IDLE);
  assign busy_o      = (state != S_IDLE);
  assign req_o       = (state == S_REQ);
  assign add_o       = addr_p0;
  assign wen_o       = wen_p0;
  assign wdata_o     = wdata_p0;
  assign be_o        = be_p0;
  assign id_o        = id_p0;
  assign rsp_valid_o = (state == S_RESP);
  assign rsp_rdata_o = rdata_p1;
  assign rsp_err_o   = err_p1;

endmodule

// File: tb/tb_lockstep_periph_master.sv
// Directed bench for lockstep_periph_master with a response scoreboard.
module tb_lockstep_periph_master;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic        cmd_wen_i;
  logic [31:0] cmd_addr_i;
  logic [31:0] cmd_wdata_i;
  logic [3:0]  cmd_be_i;
  logic        rsp_valid_o;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;
  logic        req_o;
  logic [31:0] add_o;
  logic        wen_o;
  logic [31:0] wdata_o;
  logic [3:0]  be_o;
  logic [1:0]  id_o;
  logic        gnt_i;
  logic        r_valid_i;
  logic        r_opc_i;
  logic [1:0]  r_id_i;
  logic [31:0] r_rdata_i;
  logic        busy_o;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   checks    = 0;
  int   errors    = 0;
  int   rsp_count = 0;

  lockstep_periph_master #(
    .ID_WIDTH  (2),
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .MASTER_ID (0),
    .TIMEOUT   (4)
  ) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .cmd_valid_i(cmd_valid_i),
    .cmd_ready_o(cmd_ready_o),
    .cmd_wen_i  (cmd_wen_i),
    .cmd_addr_i (cmd_addr_i),
    .cmd_wdata_i(cmd_wdata_i),
    .cmd_be_i   (cmd_be_i),
    .rsp_valid_o(rsp_valid_o),
    .rsp_rdata_o(rsp_rdata_o),
    .rsp_err_o  (rsp_err_o),
    .req_o      (req_o),
    .add_o      (add_o),
    .wen_o      (wen_o),
    .wdata_o    (wdata_o),
    .be_o       (be_o),
    .id_o       (id_o),
    .gnt_i      (gnt_i),
    .r_valid_i  (r_valid_i),
    .r_opc_i    (r_opc_i),
    .r_id_i     (r_id_i),
    .r_rdata_i  (r_rdata_i),
    .busy_o     (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // one clock; inputs are driven and outputs sampled 1 time unit after the edge
  task automatic cycle();
    @(posedge clk_i);
    #1;
  endtask

  // scoreboard: compare every response pulse against the oldest expectation
  always @(negedge clk_i) begin
    if (rst_ni === 1'b1 && rsp_valid_o === 1'b1) begin
      rsp_count++;
      chk("rsp_no_req_overlap", req_o, 1'b0);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL rsp_unexpected: observed=%0h expected=none", rsp_rdata_o);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("rsp_rdata", rsp_rdata_o, e.rdata);
        chk("rsp_err", rsp_err_o, e.err);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  // full transaction with gnt_dly cycles of no-grant and rsp_dly idle cycles in WAIT_RSP
  task automatic run_txn(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be, input int gnt_dly, input int rsp_dly,
                         input logic opc, input logic [1:0] rid, input logic [31:0] rdata);
    exp_t e;
    e.rdata = wen ? rdata : 32'h0;
    e.err   = opc | (rid != 2'd0);
    sb.push_back(e);
    chk("txn_cmd_ready_idle", cmd_ready_o, 1'b1);
    cmd_valid_i = 1'b1;
    cmd_wen_i   = wen;
    cmd_addr_i  = addr;
    cmd_wdata_i = wdata;
    cmd_be_i    = be;
    cycle();
    cmd_valid_i = 1'b0;
    cmd_wen_i   = ~wen;
    cmd_addr_i  = ~addr;
    cmd_wdata_i = ~wdata;
    cmd_be_i    = ~be;
    for (int i = 0; i < gnt_dly; i++) begin
      chk("txn_req_wait_gnt", req_o, 1'b1);
      chk("txn_add_stable", add_o, addr);
      cycle();
    end
    chk("txn_req", req_o, 1'b1);
    chk("txn_add", add_o, addr);
    chk("txn_wen", wen_o, wen);
    chk("txn_wdata", wdata_o, wdata);
    chk("txn_be", be_o, be);
    chk("txn_id", id_o, 2'd0);
    chk("txn_cmd_ready_busy", cmd_ready_o, 1'b0);
    gnt_i     = 1'b1;
    r_valid_i = 1'b1;
    r_opc_i   = 1'b1;
    r_rdata_i = 32'hBAD0BAD0;
    cycle();
    gnt_i     = 1'b0;
    r_valid_i = 1'b0;
    r_opc_i   = 1'b0;
    chk("txn_req_after_gnt", req_o, 1'b0);
    chk("txn_add_hold", add_o, addr);
    for (int i = 0; i < rsp_dly; i++) cycle();
    chk("txn_no_early_rsp", rsp_valid_o, 1'b0);
    r_valid_i = 1'b1;
    r_opc_i   = opc;
    r_id_i    = rid;
    r_rdata_i = rdata;
    cycle();
    r_valid_i = 1'b0;
    r_opc_i   = 1'b0;
    r_id_i    = 2'd0;
    chk("txn_rsp_valid", rsp_valid_o, 1'b1);
    chk("txn_busy_resp", busy_o, 1'b1);
    cycle();
    chk("txn_rsp_pulse_end", rsp_valid_o, 1'b0);
    chk("txn_back_idle", cmd_ready_o, 1'b1);
  endtask

  initial begin
    rst_ni      = 1'b0;
    cmd_valid_i = 1'b0;
    cmd_wen_i   = 1'b0;
    cmd_addr_i  = 32'h0;
    cmd_wdata_i = 32'h0;
    cmd_be_i    = 4'h0;
    gnt_i       = 1'b0;
    r_valid_i   = 1'b0;
    r_opc_i     = 1'b0;
    r_id_i      = 2'd0;
    r_rdata_i   = 32'h0;
    repeat (3) cycle();

    // reset state
    chk("rst_cmd_ready", cmd_ready_o, 1'b1);
    chk("rst_req", req_o, 1'b0);
    chk("rst_rsp_valid", rsp_valid_o, 1'b0);
    chk("rst_rsp_err", rsp_err_o, 1'b0);
    chk("rst_rsp_rdata", rsp_rdata_o, 32'h0);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_add", add_o, 32'h0);
    chk("rst_wdata", wdata_o, 32'h0);
    chk("rst_be", be_o, 4'h0);
    chk("rst_wen", wen_o, 1'b0);
    chk("rst_id", id_o, 2'd0);
    rst_ni = 1'b1;
    cycle();

    // write, immediate grant, response two cycles after grant
    run_txn(1'b0, 32'h1020_0000, 32'h0000_0001, 4'hF, 0, 1, 1'b0, 2'd0, 32'h1234_5678);
    // read, grant after three idle request cycles
    run_txn(1'b1, 32'h1020_0004, 32'h0, 4'hF, 3, 0, 1'b0, 2'd0, 32'hDEAD_BEEF);
    // error via r_opc_i, then via id mismatch
    run_txn(1'b1, 32'h1020_0008, 32'h0, 4'h3, 0, 0, 1'b1, 2'd0, 32'hA5A5_A5A5);
    run_txn(1'b1, 32'h1020_000C, 32'h0, 4'hC, 1, 2, 1'b0, 2'd1, 32'h5A5A_5A5A);
    chk("rsp_count_after_txns", rsp_count, 4);

    // grant never arrives: four request cycles then an error response
    sb.push_back('{rdata: 32'h0, err: 1'b1});
    cmd_valid_i = 1'b1;
    cmd_wen_i   = 1'b1;
    cmd_addr_i  = 32'h2000_0000;
    cycle();
    cmd_valid_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("to_gnt_req_held", req_o, 1'b1);
      cycle();
    end
    chk("to_gnt_req_drop", req_o, 1'b0);
    chk("to_gnt_rsp_valid", rsp_valid_o, 1'b1);
    chk("to_gnt_rsp_err", rsp_err_o, 1'b1);
    cycle();
    chk("to_gnt_idle", cmd_ready_o, 1'b1);

    // response never arrives: four wait cycles then an error response
    sb.push_back('{rdata: 32'h0, err: 1'b1});
    cmd_valid_i = 1'b1;
    cycle();
    cmd_valid_i = 1'b0;
    gnt_i       = 1'b1;
    cycle();
    gnt_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("to_rsp_waiting", rsp_valid_o, 1'b0);
      cycle();
    end
    chk("to_rsp_rsp_valid", rsp_valid_o, 1'b1);
    chk("to_rsp_rsp_err", rsp_err_o, 1'b1);
    chk("to_rsp_rdata", rsp_rdata_o, 32'h0);
    cycle();
    chk("rsp_count_after_timeouts", rsp_count, 6);

    // reset while waiting for a response, late response afterwards
    cmd_valid_i = 1'b1;
    cmd_addr_i  = 32'h3000_0000;
    cycle();
    cmd_valid_i = 1'b0;
    gnt_i       = 1'b1;
    cycle();
    gnt_i  = 1'b0;
    chk("rst_mid_busy_before", busy_o, 1'b1);
    rst_ni = 1'b0;
    cycle();
    rst_ni    = 1'b1;
    r_valid_i = 1'b1;
    r_opc_i   = 1'b1;
    r_rdata_i = 32'hFFFF_FFFF;
    cycle();
    r_valid_i = 1'b0;
    r_opc_i   = 1'b0;
    chk("rst_mid_rsp_valid", rsp_valid_o, 1'b0);
    chk("rst_mid_cmd_ready", cmd_ready_o, 1'b1);
    chk("rst_mid_busy", busy_o, 1'b0);
    chk("rst_mid_req", req_o, 1'b0);
    chk("rst_mid_rdata", rsp_rdata_o, 32'h0);
    chk("rst_mid_err", rsp_err_o, 1'b0);
    chk("rst_mid_add", add_o, 32'h0);
    cycle();
    chk("rsp_count_after_reset", rsp_count, 6);

    // back-to-back: cmd_valid_i held high across two commands
    sb.push_back('{rdata: 32'h0, err: 1'b0});
    sb.push_back('{rdata: 32'hCAFE_F00D, err: 1'b0});
    cmd_valid_i = 1'b1;
    cmd_wen_i   = 1'b0;
    cmd_addr_i  = 32'h0000_0100;
    cmd_wdata_i = 32'h0000_0055;
    cmd_be_i    = 4'hF;
    cycle();
    cmd_wen_i   = 1'b1;
    cmd_addr_i  = 32'h0000_0200;
    chk("b2b_first_add", add_o, 32'h0000_0100);
    chk("b2b_not_ready", cmd_ready_o, 1'b0);
    gnt_i = 1'b1;
    cycle();
    gnt_i     = 1'b0;
    r_valid_i = 1'b1;
    r_rdata_i = 32'h1111_1111;
    cycle();
    r_valid_i = 1'b0;
    chk("b2b_first_rsp", rsp_valid_o, 1'b1);
    chk("b2b_resp_not_ready", cmd_ready_o, 1'b0);
    cycle();
    chk("b2b_idle_ready", cmd_ready_o, 1'b1);
    chk("b2b_idle_no_req", req_o, 1'b0);
    cycle();
    cmd_valid_i = 1'b0;
    chk("b2b_second_req", req_o, 1'b1);
    chk("b2b_second_add", add_o, 32'h0000_0200);
    chk("b2b_second_wen", wen_o, 1'b1);
    gnt_i = 1'b1;
    cycle();
    gnt_i     = 1'b0;
    r_valid_i = 1'b1;
    r_rdata_i = 32'hCAFE_F00D;
    cycle();
    r_valid_i = 1'b0;
    chk("b2b_second_rsp", rsp_valid_o, 1'b1);
    repeat (3) cycle();

    chk("sb_drained", sb.size(), 0);
    chk("rsp_count_final", rsp_count, 8);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
